// File: rtl/series_pkg.sv
// Shared types and constants for the series sum engine.
// The SERIES_SQUARES_EN build option only affects series_term.
package series_pkg;

  localparam int unsigned DEF_N_W   = 8;
  localparam int unsigned DEF_SUM_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/series_term.sv
// Combinational term generator: term(i) = i, or i*i when SERIES_SQUARES_EN is defined and mode selects squares.
// Without SERIES_SQUARES_EN the mode input is ignored and no multiplier is built.
module series_term
  import series_pkg::*;
#(
  parameter int unsigned N_W   = DEF_N_W,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic [N_W-1:0]   i,
  input  logic             mode,
  output logic [SUM_W-1:0] term
);

  localparam int unsigned SQ_W = 2 * N_W;

`ifdef SERIES_SQUARES_EN
  logic [SQ_W-1:0] square;

  assign square = SQ_W'(i) * SQ_W'(i);
  assign term   = (mode == MODE_SQUARE) ? SUM_W'(square) : SUM_W'(i);
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign term        = SUM_W'(i);
`endif

endmodule

// File: rtl/series_sum_engine.sv
// Sums term(i) for i = N down to 1, one term per clock, with valid/ready on both sides.
// Define SERIES_SQUARES_EN to enable the sum-of-squares mode in series_term.
module series_sum_engine
  import series_pkg::*;
#(
  parameter int unsigned N_W   = DEF_N_W,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N_W-1:0]   N,
  input  logic             N_valid,
  output logic             N_ready,
  input  logic             Mode,
  output logic [SUM_W-1:0] Sum_out,
  output logic             Sum_valid,
  input  logic             Sum_ready,
  output logic             Overflow,
  output logic             Busy
);

  state_t           state;
  logic [N_W-1:0]   i_cnt;
  logic [SUM_W-1:0] acc;
  logic             ovf;
  logic             mode_q;
  logic [SUM_W-1:0] term;
  logic [SUM_W:0]   sum_ext;
  logic             ovf_next;

  series_term #(
    .N_W   (N_W),
    .SUM_W (SUM_W)
  ) u_term (
    .i    (i_cnt),
    .mode (mode_q),
    .term (term)
  );

  // One extra bit catches the carry-out that marks a wrap.
  assign sum_ext  = {1'b0, acc} + {1'b0, term};
  assign ovf_next = ovf | sum_ext[SUM_W];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      i_cnt     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      mode_q    <= MODE_LINEAR;
      Sum_out   <= '0;
      Sum_valid <= 1'b0;
      Overflow  <= 1'b0;
      N_ready   <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (N_valid) begin
            i_cnt    <= N;
            acc      <= '0;
            ovf      <= 1'b0;
            mode_q   <= Mode;
            Overflow <= 1'b0;
            N_ready  <= 1'b0;
            Busy     <= 1'b1;
            if (N == '0) begin
              state     <= DONE;
              Sum_out   <= '0;
              Sum_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end

        // Count i down to 1; the edge adding term(1) publishes the result.
        ACCUM: begin
          acc   <= sum_ext[SUM_W-1:0];
          ovf   <= ovf_next;
          i_cnt <= i_cnt - N_W'(1);
          if (i_cnt == N_W'(1)) begin
            state     <= DONE;
            Sum_out   <= sum_ext[SUM_W-1:0];
            Overflow  <= ovf_next;
            Sum_valid <= 1'b1;
          end
        end

        DONE: begin
          if (Sum_ready) begin
            state     <= IDLE;
            Sum_valid <= 1'b0;
            N_ready   <= 1'b1;
            Busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          Sum_valid <= 1'b0;
          N_ready   <= 1'b1;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_series_sum_engine.sv
// Directed bench for series_sum_engine: default widths plus a SUM_W=12 instance for wrap checks.
module tb_series_sum_engine;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  N;
  logic        N_valid;
  logic        Mode;
  logic        Sum_ready;
  logic        N_ready;
  logic [23:0] Sum_out;
  logic        Sum_valid;
  logic        Overflow;
  logic        Busy;
  logic        n_ready12;
  logic [11:0] sum_out12;
  logic        sum_valid12;
  logic        overflow12;
  logic        busy12;

  int n_cmp = 0;
  int n_err = 0;

  series_sum_engine #(.N_W(8), .SUM_W(24)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .N         (N),
    .N_valid   (N_valid),
    .N_ready   (N_ready),
    .Mode      (Mode),
    .Sum_out   (Sum_out),
    .Sum_valid (Sum_valid),
    .Sum_ready (Sum_ready),
    .Overflow  (Overflow),
    .Busy      (Busy)
  );

  series_sum_engine #(.N_W(8), .SUM_W(12)) dut12 (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .N         (N),
    .N_valid   (N_valid),
    .N_ready   (n_ready12),
    .Mode      (Mode),
    .Sum_out   (sum_out12),
    .Sum_valid (sum_valid12),
    .Sum_ready (Sum_ready),
    .Overflow  (overflow12),
    .Busy      (busy12)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request and wait for its result; leaves the bench at a negedge in DONE.
  task automatic run_case(input string tag, input int n, input logic mode,
                          input int exp_sum, input logic exp_ovf);
    int k;
    @(negedge Clk);
    check({tag, "_nready"}, 32'(N_ready), 32'd1);
    N       = 8'(n);
    Mode    = mode;
    N_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    N_valid = 1'b0;
    N       = 8'hA5;
    Mode    = ~mode;
    k = 0;
    while (!Sum_valid && k < 600) begin
      @(posedge Clk);
      @(negedge Clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(n));
    check({tag, "_sum"}, 32'(Sum_out), 32'(exp_sum));
    check({tag, "_ovf"}, 32'(Overflow), 32'(exp_ovf));
    check({tag, "_busy"}, 32'(Busy), 32'd1);
  endtask

  initial begin
    Rst_n     = 1'b0;
    N         = '0;
    N_valid   = 1'b0;
    Mode      = 1'b0;
    Sum_ready = 1'b1;
    repeat (2) @(negedge Clk);
    check("rst_valid", 32'(Sum_valid), 32'd0);
    check("rst_nready", 32'(N_ready), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_sum", 32'(Sum_out), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    Rst_n = 1'b1;

    run_case("n10", 10, 1'b0, 55, 1'b0);
    run_case("n0", 0, 1'b0, 0, 1'b0);
    run_case("n1", 1, 1'b0, 1, 1'b0);
    run_case("n255", 255, 1'b0, 32640, 1'b0);
    run_case("n100", 100, 1'b0, 5050, 1'b0);
    check("w12_sum", 32'(sum_out12), 32'd954);
    check("w12_ovf", 32'(overflow12), 32'd1);
    check("w12_valid", 32'(sum_valid12), 32'd1);

`ifdef SERIES_SQUARES_EN
    run_case("sq10", 10, 1'b1, 385, 1'b0);
    check("w12_ovf_clear", 32'(overflow12), 32'd0);
    run_case("sq255", 255, 1'b1, 5559680, 1'b0);
`else
    run_case("sq10", 10, 1'b1, 55, 1'b0);
    check("w12_ovf_clear", 32'(overflow12), 32'd0);
    run_case("sq255", 255, 1'b1, 32640, 1'b0);
`endif

    // Consumer stalls: result held, new requests ignored.
    @(negedge Clk);
    Sum_ready = 1'b0;
    run_case("hold", 7, 1'b0, 28, 1'b0);
    for (int c = 0; c < 5; c++) begin
      N       = 8'd3;
      N_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      check("hold_sum", 32'(Sum_out), 32'd28);
      check("hold_valid", 32'(Sum_valid), 32'd1);
      check("hold_nready", 32'(N_ready), 32'd0);
    end
    N_valid   = 1'b0;
    Sum_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("handoff_valid", 32'(Sum_valid), 32'd0);
    check("handoff_nready", 32'(N_ready), 32'd1);
    check("handoff_busy", 32'(Busy), 32'd0);

    // Reset in the middle of a long computation.
    N       = 8'd200;
    N_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    N_valid = 1'b0;
    repeat (20) @(negedge Clk);
    check("abort_busy_before", 32'(Busy), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(Sum_valid), 32'd0);
    check("abort_nready", 32'(N_ready), 32'd1);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_sum", 32'(Sum_out), 32'd0);
    check("abort_ovf", 32'(Overflow), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    run_case("after_rst", 3, 1'b0, 6, 1'b0);

    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
